// File: rtl/cpu_pkg.sv
// Shared definitions for the RISC core front-end.
// Provides the instruction width, architectural register addresses used by
// the decoder, the canonical NOP encoding and the fetch FSM state type.
package cpu_pkg;

    localparam int INSTR_W = 16;

    localparam logic [3:0] PC_REG_ADDR = 4'b1111;
    localparam logic [3:0] LR_REG_ADDR = 4'b1110;
    localparam logic [3:0] SP_REG_ADDR = 4'b1101;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'hBF00;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used by the fetch unit for both the returned
// instruction entries and the pc tag queue.
//   clk, reset : clock, asynchronous active-low reset
//   push/wdata : write an entry (accepted when not full, or when popping)
//   pop        : remove the head entry (ignored when empty)
//   flush      : empty the FIFO; has priority over push and pop
//   rdata      : head entry (registered storage, no bypass)
//   full/empty/count : occupancy status
module fetch_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: issues sequential halfword fetch requests,
// buffers returned instructions with their pc in a prefetch FIFO, and hands
// them to the decoder one at a time. A redirect flushes buffered entries,
// marks in-flight responses for discard and restarts fetch at the target.
//
// Handshakes (all sampled on the rising edge of clk):
//   imem_req/imem_gnt       : a request transfers when both are 1; while
//                             imem_req is 1 and not granted imem_addr is held
//                             (a redirect cycle is the only exception).
//   imem_rvalid             : one in-order response per cycle, no backpressure.
//   instr_valid/instr_ready : the head entry transfers when both are 1.
//
// Ports:
//   clk, reset              : clock, asynchronous active-low reset
//   imem_req/addr/gnt       : fetch request channel
//   imem_rvalid/rdata       : fetch response channel
//   instr_valid/instruction/instr_pc/instr_ready : decoder channel
//   redirect_valid/pc       : branch redirect
//   halt                    : stop issuing new requests
//   dbg_state               : current fetch FSM state
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output fetch_state_t       dbg_state
);

    localparam int CW = $clog2(DEPTH+1);

    fetch_state_t      state;
    logic [ADDR_W-1:0] fpc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outstanding_nxt;
    logic [CW-1:0]     discard;
    logic [CW:0]       credit_sum;
    logic              grant;
    logic              live_rsp;

    logic [CW-1:0]     data_count;
    logic              data_full;
    logic              data_empty;
    logic [ADDR_W-1:0] tag_pc;
    logic [CW-1:0]     tag_count;
    logic              tag_full;
    logic              tag_empty;
    logic              unused_status;

    // Stale requests still occupy credit until their responses return. This
    // keeps the total in flight within DEPTH so the counters never overflow.
    assign credit_sum = {1'b0, data_count} + {1'b0, outstanding};
    assign imem_req   = (state == RUN) && (credit_sum < (CW+1)'(DEPTH));
    assign imem_addr  = fpc;
    assign grant      = imem_req && imem_gnt;
    assign live_rsp   = imem_rvalid && (discard == '0);
    assign dbg_state  = state;

    always_comb begin
        outstanding_nxt = outstanding;
        case ({grant, imem_rvalid})
            2'b10:   outstanding_nxt = outstanding + 1'b1;
            2'b01:   if (outstanding != '0) outstanding_nxt = outstanding - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            fpc         <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            case (state)
                BOOT:    state <= RUN;
                RUN:     if (halt) state <= HALTED;
                HALTED:  if (!halt) state <= RUN;
                default: state <= BOOT;
            endcase
            if (redirect_valid) begin
                // Everything still in flight after this cycle, including a
                // grant taken in this very cycle, belongs to the old stream.
                fpc     <= redirect_pc;
                discard <= outstanding_nxt;
            end else begin
                if (grant) fpc <= fpc + 1'b1;
                if (imem_rvalid && (discard != '0)) discard <= discard - 1'b1;
            end
        end
    end

    // pc of each live request, captured at grant and consumed by its response.
    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_q (
        .clk   (clk),
        .reset (reset),
        .push  (grant),
        .pop   (live_rsp),
        .flush (redirect_valid),
        .wdata (fpc),
        .rdata (tag_pc),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    fetch_fifo #(.WIDTH(INSTR_W + ADDR_W), .DEPTH(DEPTH)) u_data_q (
        .clk   (clk),
        .reset (reset),
        .push  (live_rsp),
        .pop   (instr_ready),
        .flush (redirect_valid),
        .wdata ({imem_rdata, tag_pc}),
        .rdata ({instruction, instr_pc}),
        .full  (data_full),
        .empty (data_empty),
        .count (data_count)
    );

    assign instr_valid   = !data_empty;
    assign unused_status = ^{tag_full, tag_empty, tag_count, data_full};

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic         clk;
    logic         reset;
    logic         imem_req;
    logic [15:0]  imem_addr;
    logic         imem_gnt;
    logic         imem_rvalid;
    logic [15:0]  imem_rdata;
    logic         instr_valid;
    logic [15:0]  instruction;
    logic [15:0]  instr_pc;
    logic         instr_ready;
    logic         redirect_valid;
    logic [15:0]  redirect_pc;
    logic         halt;
    fetch_state_t dbg_state;

    instr_fetch_unit #(.ADDR_W(16), .DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          grant_cnt = 0;
    int          consumed = 0;
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    int          last_due = 0;
    logic        last_req;
    logic [15:0] last_addr;
    logic        last_v;
    logic [15:0] prev_pc = 16'h0;
    logic [15:0] first_pc = 16'h0;
    bit          track_first = 0;
    bit          saw_wrap = 0;

    // Reference model: the decoder must see the fetch stream as consecutive
    // pcs starting at the last restart point, carrying memory contents.
    logic [15:0] exp_fetch = RESET_PC;
    logic [31:0] exp_q[$];
    // Memory model: in-order pending responses with their due cycle.
    logic [15:0] pend_addr[$];
    int          pend_due[$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] w;
        w = (a * 16'h9E37) ^ 16'hA5C3;
        return w;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_imem_req", imem_req, 1'b0);
        check_eq("rst_imem_addr", imem_addr, RESET_PC);
        check_eq("rst_instr_valid", instr_valid, 1'b0);
        check_eq("rst_instruction", instruction, 16'h0000);
        check_eq("rst_instr_pc", instr_pc, 16'h0000);
        check_eq("rst_state", dbg_state, BOOT);
    endtask

    task automatic clear_model();
        pend_addr.delete();
        pend_due.delete();
        exp_q.delete();
        exp_fetch = RESET_PC;
        last_due = cyc;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 16'h0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0;
        halt = 1'b0;
    endtask

    // ---------------- driver + scoreboard, one cycle ----------------
    // Outputs are sampled at the falling edge; the inputs driven here take
    // effect at the next rising edge together with the sampled outputs.
    task automatic step(input bit rdy, input bit redir, input logic [15:0] rpc, input bit hlt);
        logic        s_req, s_v, g;
        logic [15:0] s_addr, s_ins, s_pc;
        logic [31:0] e;
        int          due;
        @(negedge clk);
        cyc++;
        s_req = imem_req;  s_addr = imem_addr;
        s_v = instr_valid; s_ins = instruction; s_pc = instr_pc;
        last_req = s_req; last_addr = s_addr; last_v = s_v;

        g = ($urandom_range(99) < gnt_pct);
        imem_gnt = g;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'($urandom);
        end
        instr_ready = rdy;
        redirect_valid = redir;
        redirect_pc = rpc;
        halt = hlt;

        if (s_req && g) begin
            grant_cnt++;
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_addr.push_back(s_addr);
            pend_due.push_back(due);
            check_eq("fetch_addr", s_addr, exp_fetch);
            if (!redir) exp_q.push_back({exp_fetch, mem_word(exp_fetch)});
            exp_fetch++;
        end

        if (redir) begin
            exp_q.delete();
            exp_fetch = rpc;
        end else if (s_v && rdy) begin
            consumed++;
            check_eq("exp_q_nonempty", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("instr_pc", s_pc, e[31:16]);
                check_eq("instruction", s_ins, e[15:0]);
            end
            if (track_first) begin
                first_pc = s_pc;
                track_first = 0;
            end
            if (s_pc == 16'h0000 && prev_pc == 16'hFFFF) saw_wrap = 1;
            prev_pc = s_pc;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  c0;
        bit  hlt_r;
        cyc = 0;
        reset = 1'b0;
        clear_model();

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs();
        @(negedge clk);
        reset = 1'b1;
        #1 check_eq("boot_no_req", imem_req, 1'b0);

        // Decoder stalled: exactly DEPTH grants, then requests stop
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        grant_cnt = 0;
        step(0, 0, 16'h0, 0);
        check_eq("first_req", last_req, 1'b1);
        check_eq("first_addr", last_addr, RESET_PC);
        repeat (19) step(0, 0, 16'h0, 0);
        check_eq("stall_grants", grant_cnt, 4);
        check_eq("stall_req_low", last_req, 1'b0);
        check_eq("stall_valid", last_v, 1'b1);

        // Release decoder: resume, then sustained one instruction per cycle
        repeat (20) step(1, 0, 16'h0, 0);
        c0 = consumed;
        repeat (40) step(1, 0, 16'h0, 0);
        check_eq("throughput", consumed - c0, 40);

        // Redirect with two requests in flight (latency 2)
        lat_min = 2; lat_max = 2;
        repeat (20) step(1, 0, 16'h0, 0);
        step(1, 1, 16'h0040, 0);
        track_first = 1;
        step(1, 0, 16'h0, 0);
        check_eq("redir_valid_low", last_v, 1'b0);
        check_eq("redir_req", last_req, 1'b1);
        check_eq("redir_addr", last_addr, 16'h0040);
        repeat (20) step(1, 0, 16'h0, 0);
        check_eq("redir_first_pc", first_pc, 16'h0040);

        // Address wrap at the top of the address space
        gnt_pct = 80; lat_min = 1; lat_max = 3;
        saw_wrap = 0;
        step(1, 1, 16'hFFFD, 0);
        repeat (40) step(1, 0, 16'h0, 0);
        check_eq("pc_wrap", saw_wrap, 1'b1);

        // Halt mid-stream: no new requests, in-flight responses delivered
        gnt_pct = 100; lat_min = 2; lat_max = 2;
        repeat (10) step(1, 0, 16'h0, 0);
        step(1, 0, 16'h0, 1);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 16'h0, 1);
            check_eq("halt_no_req", last_req, 1'b0);
        end
        check_eq("halt_drained", exp_q.size(), 0);
        c0 = consumed;
        repeat (20) step(1, 0, 16'h0, 0);
        check_eq("halt_resume", consumed > c0, 1'b1);

        // Randomized traffic
        gnt_pct = 70; lat_min = 1; lat_max = 4;
        hlt_r = 0;
        c0 = consumed;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 4) hlt_r = ~hlt_r;
            step($urandom_range(3) != 0, $urandom_range(99) < 3, 16'($urandom), hlt_r);
        end
        gnt_pct = 100;
        repeat (30) step(1, 0, 16'h0, 0);
        check_eq("random_progress", (consumed - c0) > 200, 1'b1);

        // Asynchronous reset mid-cycle with a full FIFO
        lat_min = 1; lat_max = 1;
        repeat (12) step(0, 0, 16'h0, 0);
        check_eq("full_before_reset", last_v, 1'b1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset_outputs();
        clear_model();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1 check_eq("boot2_no_req", imem_req, 1'b0);
        step(1, 0, 16'h0, 0);
        check_eq("post_reset_req", last_req, 1'b1);
        check_eq("post_reset_addr", last_addr, RESET_PC);
        repeat (30) step(1, 0, 16'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
